// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arbiter_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and data ports; prio_d breaks ties.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  logic   prio_d,
  output logic   grant_vld,
  output owner_t grant_own
);

  always_comb begin
    grant_vld = if_req | d_req;
    grant_own = OWN_IF;
    if (d_req && (!if_req || prio_d))
      grant_own = OWN_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a registered-read memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is data-port priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t grant_own;
  logic   rst_q;
  logic   idle_ok;
  logic   grant_vld;
  logic   grant_d;
  logic   grant_if;
  logic   prio_d;
  logic   rsp_vld;

  // rst_q blanks every output for the cycle that follows a reset edge
  assign idle_ok = (state_q == IDLE) && !rst && !rst_q;

`ifdef MEM_ARB_RR_EN
  logic last_d_q;

  always_ff @(posedge clk) begin
    if (rst)
      last_d_q <= 1'b0;
    else if (grant_vld)
      last_d_q <= grant_d;
  end

  assign prio_d = ~last_d_q;
`else
  assign prio_d = 1'b1;
`endif

  mem_arb_pick u_pick (
    .if_req    (if_req & idle_ok),
    .d_req     (d_req & idle_ok),
    .prio_d    (prio_d),
    .grant_vld (grant_vld),
    .grant_own (grant_own)
  );

  assign grant_d  = grant_vld && (grant_own == OWN_D);
  assign grant_if = grant_vld && (grant_own == OWN_IF);

  always_comb begin
    if_ready  = grant_if;
    d_ready   = grant_d;
    mem_we    = grant_d & d_we;
    mem_re    = grant_if | (grant_d & ~d_we);
    mem_addr  = grant_if ? if_addr : d_addr;
    mem_wdata = d_wdata;
    if (rst_q) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
    // a reset landing in RESP must swallow the pending response
    rsp_vld   = (state_q == RESP) && !rst;
    if_rvalid = rsp_vld && (owner_q == OWN_IF);
    d_rvalid  = rsp_vld && (owner_q == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rst_q   <= 1'b0;
    end
  end

  always_comb begin
    state_d = IDLE;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (mem_re) begin
          state_d = RESP;
          owner_d = grant_own;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand sequences, response scoreboard.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  // Registered-read memory model
  logic [DW-1:0] mem_arr [0:65535];
  logic          preload_en;

  always @(posedge clk) begin
    if (preload_en) mem_arr[16'h0010] <= 16'hA5A5;
    if (mem_re) mem_rdata <= mem_arr[mem_addr];
    if (mem_we) mem_arr[mem_addr] <= mem_wdata;
  end

  typedef struct packed {
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
  } drv_t;

  typedef struct packed {
    drv_t          in;
    logic          e_if_ready;
    logic          e_d_ready;
    logic          e_we;
    logic          e_re;
    logic [AW-1:0] e_addr;
  } vec_t;

  typedef struct packed {
    logic          is_d;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  rsp_t          sb[$];
  logic [DW-1:0] ref_mem [0:65535];
  vec_t          tbl [15];

  function automatic drv_t mk(input logic r, input logic ir, input logic [AW-1:0] ia,
                              input logic dr, input logic dw, input logic [AW-1:0] da,
                              input logic [DW-1:0] dd);
    drv_t d;
    d.rst = r; d.if_req = ir; d.if_addr = ia;
    d.d_req = dr; d.d_we = dw; d.d_addr = da; d.d_wdata = dd;
    return d;
  endfunction

  function automatic vec_t mv(input drv_t d, input logic eir, input logic edr,
                              input logic ewe, input logic ere, input logic [AW-1:0] ea);
    vec_t v;
    v.in = d; v.e_if_ready = eir; v.e_d_ready = edr;
    v.e_we = ewe; v.e_re = ere; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h expected=%0h (cycle %0d)", name, idx, act, exp, cyc);
    end
  endtask

  // Runs every cycle: invariants plus scoreboard push/pop
  task automatic monitor();
    rsp_t e;
    chk("we_re_excl", cyc, 32'(mem_we & mem_re), 0);
    chk("rvalid_excl", cyc, 32'(if_rvalid & d_rvalid), 0);
    chk("if_no_we", cyc, 32'(if_ready & mem_we), 0);
    if (!if_rvalid) chk("if_rdata_zero", cyc, 32'(if_rdata), 0);
    if (!d_rvalid) chk("d_rdata_zero", cyc, 32'(d_rdata), 0);
    if (rst) begin
      chk("rvalid_in_rst", cyc, {30'd0, if_rvalid, d_rvalid}, 0);
      sb.delete();
    end else begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL rsp_missing[%0d] actual=none required=rvalid", cyc);
        void'(sb.pop_front());
      end
      if (if_rvalid | d_rvalid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected[%0d] actual=rvalid required=none", cyc);
        end else begin
          e = sb.pop_front();
          chk("rsp_cycle", cyc, 32'(cyc), 32'(e.due));
          chk("rsp_port_d", cyc, 32'(d_rvalid), 32'(e.is_d));
          chk("rsp_data", cyc, 32'(d_rvalid ? d_rdata : if_rdata), 32'(e.data));
        end
      end
      if (if_ready && mem_re) sb.push_back('{1'b0, ref_mem[if_addr], cyc + 1});
      if (d_ready && !d_we) sb.push_back('{1'b1, ref_mem[d_addr], cyc + 1});
      if (d_ready && d_we) ref_mem[d_addr] = d_wdata;
    end
  endtask

  task automatic step(input drv_t d);
    @(posedge clk);
    #1;
    rst = d.rst; if_req = d.if_req; if_addr = d.if_addr;
    d_req = d.d_req; d_we = d.d_we; d_addr = d.d_addr; d_wdata = d.d_wdata;
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic check_out(input int idx, input logic eir, input logic edr,
                           input logic ewe, input logic ere, input logic [AW-1:0] ea);
    chk("if_ready", idx, 32'(if_ready), 32'(eir));
    chk("d_ready", idx, 32'(d_ready), 32'(edr));
    chk("mem_we", idx, 32'(mem_we), 32'(ewe));
    chk("mem_re", idx, 32'(mem_re), 32'(ere));
    chk("mem_addr", idx, 32'(mem_addr), 32'(ea));
  endtask

  task automatic check_zero(input int idx);
    check_out(idx, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("z_mem_wdata", idx, 32'(mem_wdata), 0);
    chk("z_rvalid", idx, {30'd0, if_rvalid, d_rvalid}, 0);
    chk("z_rdata", idx, {if_rdata, d_rdata}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drv_t idle;
    drv_t both;
    logic exp_if, exp_d;
    idle = mk(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; preload_en = 1'b1;
    for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
    ref_mem[16'h0010] = 16'hA5A5;

    tbl[0]  = mv(mk(0, 0, 16'h0000, 0, 0, 16'h0033, 16'h0000), 0, 0, 0, 0, 16'h0033);
    tbl[1]  = mv(mk(0, 1, 16'h0010, 0, 0, 16'h0033, 16'h0000), 1, 0, 0, 1, 16'h0010);
    tbl[2]  = mv(mk(0, 0, 16'h0000, 0, 0, 16'h0033, 16'h0000), 0, 0, 0, 0, 16'h0033);
    tbl[3]  = mv(mk(0, 0, 16'h0000, 0, 0, 16'h0033, 16'h0000), 0, 0, 0, 0, 16'h0033);
    tbl[4]  = mv(mk(0, 0, 16'h0000, 1, 1, 16'h0020, 16'h1234), 0, 1, 1, 0, 16'h0020);
    tbl[5]  = mv(mk(0, 0, 16'h0000, 1, 1, 16'h0021, 16'h5678), 0, 1, 1, 0, 16'h0021);
    tbl[6]  = mv(mk(0, 0, 16'h0000, 1, 0, 16'h0021, 16'h0000), 0, 1, 0, 1, 16'h0021);
    tbl[7]  = mv(mk(0, 0, 16'h0000, 1, 0, 16'h0021, 16'h0000), 0, 0, 0, 0, 16'h0021);
    tbl[8]  = mv(mk(0, 0, 16'h0000, 1, 0, 16'h0021, 16'h0000), 0, 1, 0, 1, 16'h0021);
    tbl[9]  = mv(mk(0, 0, 16'h0000, 0, 0, 16'h0021, 16'h0000), 0, 0, 0, 0, 16'h0021);
    tbl[10] = mv(mk(0, 0, 16'h0000, 1, 1, 16'h0022, 16'hBEEF), 0, 1, 1, 0, 16'h0022);
    tbl[11] = mv(mk(0, 1, 16'h0022, 0, 0, 16'h0022, 16'h0000), 1, 0, 0, 1, 16'h0022);
    tbl[12] = mv(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000), 0, 0, 0, 0, 16'h0000);
    tbl[13] = mv(mk(0, 0, 16'h0000, 1, 0, 16'h0020, 16'h0000), 0, 1, 0, 1, 16'h0020);
    tbl[14] = mv(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000), 0, 0, 0, 0, 16'h0000);

    // reset and post-reset state
    step(mk(1, 0, '0, 0, 0, '0, '0));
    step(mk(1, 0, '0, 0, 0, '0, '0));
    preload_en = 1'b0;
    step(idle);
    check_zero(100);
    step(idle);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].in);
      check_out(i, tbl[i].e_if_ready, tbl[i].e_d_ready, tbl[i].e_we, tbl[i].e_re, tbl[i].e_addr);
    end

    // contention: both ports reading for 8 cycles from a fresh pointer
    step(mk(1, 0, '0, 0, 0, '0, '0));
    step(idle);
    both = mk(0, 1, 16'h0010, 1, 0, 16'h0021, '0);
    for (int k = 0; k < 8; k++) begin
      step(both);
      exp_if = RR_EN && (k % 4 == 2);
      exp_d  = RR_EN ? (k % 4 == 0) : (k % 2 == 0);
      check_out(200 + k, exp_if, exp_d, 1'b0, exp_if | exp_d, exp_if ? 16'h0010 : 16'h0021);
    end

    // reset landing in the RESP cycle of a data read
    step(mk(0, 0, '0, 1, 0, 16'h0021, '0));
    check_out(300, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0021);
    step(mk(1, 0, '0, 0, 0, '0, '0));
    chk("rst_resp_rvalid", 301, {30'd0, if_rvalid, d_rvalid}, 0);
    step(idle);
    check_zero(302);
    step(idle);
    chk("post_rst_rvalid", 303, {30'd0, if_rvalid, d_rvalid}, 0);
    step(mk(0, 0, '0, 1, 0, 16'h0020, '0));
    check_out(304, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0020);
    step(idle);
    step(idle);

    chk("sb_empty", 400, 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
